// File: rtl/cdb_arbiter_pkg.sv
// Shared types and defaults for the common data bus arbiter.
// Source encoding and the queue depth default live here so both queues and the top agree.
package cdb_arbiter_pkg;

   localparam int CDB_XLEN           = 32;
   localparam int CDB_ROB_SIZE_WIDTH = 4;
   localparam int CDB_FIFO_DEPTH     = 4;

   typedef enum logic {
      CDB_SRC_ALU = 1'b0,
      CDB_SRC_MEM = 1'b1
   } cdb_src_e;

   function automatic cdb_src_e cdb_other_src(input cdb_src_e src);
      return (src == CDB_SRC_ALU) ? CDB_SRC_MEM : CDB_SRC_ALU;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side inputs and broadcast outputs of the CDB arbiter.
// cdb_conflict_cnt exists only when CDB_STATS_EN is defined.
interface cdb_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
);

   logic              alu_ready;
   logic [DATA_W-1:0] alu_res;
   logic [ID_W-1:0]   alu_id;
   logic              mem_data_ready;
   logic [DATA_W-1:0] mem_data;
   logic [ID_W-1:0]   mem_id;

   logic              cdb_ready;
   logic [DATA_W-1:0] cdb_val;
   logic [ID_W-1:0]   cdb_id;
   logic              cdb_src;
   logic              cdb_alu_full;
   logic              cdb_mem_full;
`ifdef CDB_STATS_EN
   logic [31:0]       cdb_conflict_cnt;

   modport master (
      output alu_ready, alu_res, alu_id, mem_data_ready, mem_data, mem_id,
      input  cdb_ready, cdb_val, cdb_id, cdb_src, cdb_alu_full, cdb_mem_full,
             cdb_conflict_cnt
   );

   modport slave (
      input  alu_ready, alu_res, alu_id, mem_data_ready, mem_data, mem_id,
      output cdb_ready, cdb_val, cdb_id, cdb_src, cdb_alu_full, cdb_mem_full,
             cdb_conflict_cnt
   );
`else
   modport master (
      output alu_ready, alu_res, alu_id, mem_data_ready, mem_data, mem_id,
      input  cdb_ready, cdb_val, cdb_id, cdb_src, cdb_alu_full, cdb_mem_full
   );

   modport slave (
      input  alu_ready, alu_res, alu_id, mem_data_ready, mem_data, mem_id,
      output cdb_ready, cdb_val, cdb_id, cdb_src, cdb_alu_full, cdb_mem_full
   );
`endif

endinterface

// File: rtl/cdb_arbiter_fifo.sv
// Per-source result queue (cdb_fifo): power-of-2 depth, wrapping pointers, simultaneous push/pop.
// A push into a full queue with no pop is dropped and flagged by an assertion.
module cdb_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clr,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   // A full queue still accepts a push when the head leaves in the same cycle.
   always_comb begin
      do_pop   = pop && !clr && (count_q != '0);
      do_push  = push && !clr && ((count_q != FULL_CNT) || do_pop);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clr) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

   overflow_a: assert property (@(posedge clk) disable iff (!rst)
      !(push && !clr && !do_push))
      else $error("cdb_fifo overflow: result dropped");

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one CDB between ALU and load results, with per-source queues.
// Define CDB_STATS_EN to add the saturating tie counter cdb_conflict_cnt.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int DATA_W     = CDB_XLEN,
   parameter int ID_W       = CDB_ROB_SIZE_WIDTH,
   parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rdy,
   input  logic          flush,
   cdb_arbiter_if.slave  bus
);

   localparam int ENT_W = DATA_W + ID_W;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_THRESH = CNT_W'(FIFO_DEPTH - 1);

   logic [ENT_W-1:0] alu_head, mem_head;
   logic [CNT_W-1:0] alu_count, mem_count;
   logic             alu_queued, mem_queued;
   logic             alu_cand, mem_cand, tie;
   logic [ENT_W-1:0] alu_cand_ent, mem_cand_ent;
   logic             grant_alu, grant_mem;
   logic             alu_push, alu_pop, mem_push, mem_pop, fifo_clr;

   cdb_src_e         last_grant_q, last_grant_d;
   cdb_src_e         winner;
   logic             cdb_ready_q, cdb_ready_d;
   logic [DATA_W-1:0] cdb_val_q, cdb_val_d;
   logic [ID_W-1:0]  cdb_id_q, cdb_id_d;
   cdb_src_e         cdb_src_q, cdb_src_d;

   // The queue head always beats a same-cycle input so per-source order holds.
   assign alu_queued   = (alu_count != '0);
   assign mem_queued   = (mem_count != '0);
   assign alu_cand     = alu_queued || bus.alu_ready;
   assign mem_cand     = mem_queued || bus.mem_data_ready;
   assign alu_cand_ent = alu_queued ? alu_head : {bus.alu_res, bus.alu_id};
   assign mem_cand_ent = mem_queued ? mem_head : {bus.mem_data, bus.mem_id};
   assign tie          = alu_cand && mem_cand;

   always_comb begin
      last_grant_d = last_grant_q;
      winner       = cdb_other_src(last_grant_q);
      grant_alu    = 1'b0;
      grant_mem    = 1'b0;
      cdb_ready_d  = 1'b0;
      cdb_val_d    = cdb_val_q;
      cdb_id_d     = cdb_id_q;
      cdb_src_d    = cdb_src_q;
      if (flush) begin
         last_grant_d = CDB_SRC_ALU;
      end else begin
         if (tie) begin
            last_grant_d = winner;
            grant_mem    = (winner == CDB_SRC_MEM);
            grant_alu    = (winner == CDB_SRC_ALU);
         end else begin
            grant_alu = alu_cand;
            grant_mem = mem_cand;
         end
         if (grant_alu) begin
            cdb_ready_d = 1'b1;
            {cdb_val_d, cdb_id_d} = alu_cand_ent;
            cdb_src_d   = CDB_SRC_ALU;
         end else if (grant_mem) begin
            cdb_ready_d = 1'b1;
            {cdb_val_d, cdb_id_d} = mem_cand_ent;
            cdb_src_d   = CDB_SRC_MEM;
         end
      end
   end

   // An input is queued unless it was bypassed straight onto the bus.
   assign fifo_clr = rdy && flush;
   assign alu_push = rdy && !flush && bus.alu_ready && !(grant_alu && !alu_queued);
   assign alu_pop  = rdy && !flush && grant_alu && alu_queued;
   assign mem_push = rdy && !flush && bus.mem_data_ready && !(grant_mem && !mem_queued);
   assign mem_pop  = rdy && !flush && grant_mem && mem_queued;

   cdb_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (alu_push),
      .pop   (alu_pop),
      .clr   (fifo_clr),
      .din   ({bus.alu_res, bus.alu_id}),
      .head  (alu_head),
      .count (alu_count)
   );

   cdb_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (mem_push),
      .pop   (mem_pop),
      .clr   (fifo_clr),
      .din   ({bus.mem_data, bus.mem_id}),
      .head  (mem_head),
      .count (mem_count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant_q <= CDB_SRC_ALU;
         cdb_ready_q  <= 1'b0;
         cdb_val_q    <= '0;
         cdb_id_q     <= '0;
         cdb_src_q    <= CDB_SRC_ALU;
      end else if (rdy) begin
         last_grant_q <= last_grant_d;
         cdb_ready_q  <= cdb_ready_d;
         cdb_val_q    <= cdb_val_d;
         cdb_id_q     <= cdb_id_d;
         cdb_src_q    <= cdb_src_d;
      end
   end

   assign bus.cdb_ready    = cdb_ready_q;
   assign bus.cdb_val      = cdb_val_q;
   assign bus.cdb_id       = cdb_id_q;
   assign bus.cdb_src      = cdb_src_q;
   assign bus.cdb_alu_full = (alu_count >= FULL_THRESH);
   assign bus.cdb_mem_full = (mem_count >= FULL_THRESH);

`ifdef CDB_STATS_EN
   logic [31:0] conflict_cnt_q, conflict_cnt_d;

   // Survives flush on purpose; only reset clears the statistics.
   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      if (tie && !flush && (conflict_cnt_q != '1)) conflict_cnt_d = conflict_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) conflict_cnt_q <= '0;
      else if (rdy) conflict_cnt_q <= conflict_cnt_d;
   end

   assign bus.cdb_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed stimulus pushes expected broadcasts, a monitor pops and compares.
module tb_cdb_arbiter;

   typedef struct packed {
      logic [31:0] val;
      logic [3:0]  id;
      logic        src;
   } exp_t;

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic rdy   = 1'b1;
   logic flush = 1'b0;
   logic upd   = 1'b0;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   cdb_arbiter_if #(.DATA_W(32), .ID_W(4)) bus();

   cdb_arbiter #(.DATA_W(32), .ID_W(4), .FIFO_DEPTH(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .rdy   (rdy),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of producer inputs; returns 1 time unit after the edge.
   task automatic applyStimulus(input logic av, input logic [31:0] ar, input logic [3:0] ai,
                                input logic mv, input logic [31:0] mr, input logic [3:0] mi);
      bus.alu_ready      = av;
      bus.alu_res        = ar;
      bus.alu_id         = ai;
      bus.mem_data_ready = mv;
      bus.mem_data       = mr;
      bus.mem_id         = mi;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0);
   endtask

   task automatic expectResult(input logic [31:0] v, input logic [3:0] id, input logic src);
      exp_t e;
      e.val = v;
      e.id  = id;
      e.src = src;
      sb.push_back(e);
   endtask

   task automatic waitDrain(input string name);
      for (int i = 0; i < 40 && sb.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      checkOutput(name, 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst   = 1'b0;
      rdy   = 1'b1;
      flush = 1'b0;
      idle(2);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Only cycles where the DUT actually updated carry a new broadcast.
   always @(posedge clk) upd <= rdy && rst;

   always @(negedge clk) begin
      exp_t e;
      if (rst && upd && bus.cdb_ready) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_grant", 64'(bus.cdb_ready), 64'd0);
         end else begin
            e = sb.pop_front();
            checkOutput("sb_val", 64'(bus.cdb_val), 64'(e.val));
            checkOutput("sb_id",  64'(bus.cdb_id),  64'(e.id));
            checkOutput("sb_src", 64'(bus.cdb_src), 64'(e.src));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.alu_ready      = 1'b0;
      bus.alu_res        = '0;
      bus.alu_id         = '0;
      bus.mem_data_ready = 1'b0;
      bus.mem_data       = '0;
      bus.mem_id         = '0;

      // Reset state
      idle(2);
      checkOutput("rst_ready",    64'(bus.cdb_ready),    64'd0);
      checkOutput("rst_val",      64'(bus.cdb_val),      64'd0);
      checkOutput("rst_id",       64'(bus.cdb_id),       64'd0);
      checkOutput("rst_src",      64'(bus.cdb_src),      64'd0);
      checkOutput("rst_alu_full", 64'(bus.cdb_alu_full), 64'd0);
      checkOutput("rst_mem_full", 64'(bus.cdb_mem_full), 64'd0);
`ifdef CDB_STATS_EN
      checkOutput("rst_conflict", 64'(bus.cdb_conflict_cnt), 64'd0);
`endif
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // 1: single-source bypass with one cycle latency, hold when idle
      expectResult(32'h0000_00AA, 4'd3, 1'b0);
      applyStimulus(1'b1, 32'h0000_00AA, 4'd3, 1'b0, 32'h0, 4'h0);
      checkOutput("t1_latency_ready", 64'(bus.cdb_ready), 64'd1);
      checkOutput("t1_val",           64'(bus.cdb_val),   64'hAA);
      idle(1);
      checkOutput("t1_idle_ready",    64'(bus.cdb_ready), 64'd0);
      checkOutput("t1_idle_val_hold", 64'(bus.cdb_val),   64'hAA);
      checkOutput("t1_alu_full",      64'(bus.cdb_alu_full), 64'd0);
      expectResult(32'h0000_00BB, 4'd7, 1'b1);
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 32'h0000_00BB, 4'd7);
      checkOutput("t1_mem_src",       64'(bus.cdb_src),   64'd1);
      idle(1);
      waitDrain("t1_drain");

      // 2: first tie after reset goes to memory
      doReset();
      expectResult(32'h22, 4'd2, 1'b1);
      expectResult(32'h11, 4'd1, 1'b0);
      applyStimulus(1'b1, 32'h11, 4'd1, 1'b1, 32'h22, 4'd2);
      checkOutput("t2_first_src", 64'(bus.cdb_src), 64'd1);
      checkOutput("t2_first_val", 64'(bus.cdb_val), 64'h22);
      idle(1);
      checkOutput("t2_second_src", 64'(bus.cdb_src), 64'd0);
      checkOutput("t2_second_val", 64'(bus.cdb_val), 64'h11);
      idle(1);
      checkOutput("t2_done_ready", 64'(bus.cdb_ready), 64'd0);
      waitDrain("t2_drain");

      // 3: six sustained ties alternate grants and fill both queues to three
      doReset();
      for (int i = 0; i < 6; i++) begin
         expectResult(32'h400 + 32'(i), 4'(8 + i), 1'b1);
         expectResult(32'h300 + 32'(i), 4'(i), 1'b0);
      end
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 32'h300 + 32'(i), 4'(i), 1'b1, 32'h400 + 32'(i), 4'(8 + i));
         if (i == 3) checkOutput("t3_alu_full_c3", 64'(bus.cdb_alu_full), 64'd0);
         if (i == 4) begin
            checkOutput("t3_alu_full_c4", 64'(bus.cdb_alu_full), 64'd1);
            checkOutput("t3_mem_full_c4", 64'(bus.cdb_mem_full), 64'd0);
         end
         if (i == 5) checkOutput("t3_mem_full_c5", 64'(bus.cdb_mem_full), 64'd1);
      end
      idle(8);
      waitDrain("t3_drain");
      checkOutput("t3_alu_full_end", 64'(bus.cdb_alu_full), 64'd0);

      // 4: flush clears queues and discards its own-cycle inputs
      doReset();
      expectResult(32'h600, 4'd8, 1'b1);
      expectResult(32'h500, 4'd0, 1'b0);
      expectResult(32'h601, 4'd9, 1'b1);
      expectResult(32'h501, 4'd1, 1'b0);
      expectResult(32'h602, 4'd10, 1'b1);
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, 32'h500 + 32'(i), 4'(i), 1'b1, 32'h600 + 32'(i), 4'(8 + i));
      checkOutput("t4_alu_full_pre", 64'(bus.cdb_alu_full), 64'd1);
      flush = 1'b1;
      applyStimulus(1'b1, 32'h5FF, 4'd15, 1'b1, 32'h6FF, 4'd14);
      flush = 1'b0;
      checkOutput("t4_flush_ready",    64'(bus.cdb_ready),    64'd0);
      checkOutput("t4_flush_alu_full", 64'(bus.cdb_alu_full), 64'd0);
      checkOutput("t4_flush_mem_full", 64'(bus.cdb_mem_full), 64'd0);
      expectResult(32'h5A5, 4'd5, 1'b0);
      applyStimulus(1'b1, 32'h5A5, 4'd5, 1'b0, 32'h0, 4'h0);
      checkOutput("t4_post_ready", 64'(bus.cdb_ready), 64'd1);
      checkOutput("t4_post_id",    64'(bus.cdb_id),    64'd5);
      idle(2);
      waitDrain("t4_drain");

      // 5: rdy low freezes outputs and queues, inputs ignored
      doReset();
      expectResult(32'h702, 4'd2, 1'b1);
      expectResult(32'h701, 4'd1, 1'b0);
      expectResult(32'h704, 4'd4, 1'b1);
      expectResult(32'h703, 4'd3, 1'b0);
      applyStimulus(1'b1, 32'h701, 4'd1, 1'b1, 32'h702, 4'd2);
      applyStimulus(1'b1, 32'h703, 4'd3, 1'b1, 32'h704, 4'd4);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'hDEAD, 4'd9, 1'b1, 32'hBEEF, 4'd9);
         checkOutput("t5_frozen_ready", 64'(bus.cdb_ready), 64'd1);
         checkOutput("t5_frozen_val",   64'(bus.cdb_val),   64'h701);
         checkOutput("t5_frozen_src",   64'(bus.cdb_src),   64'd0);
      end
      rdy = 1'b1;
      idle(3);
      waitDrain("t5_drain");

      // 6: tie statistics and asynchronous reset mid-run
      doReset();
      expectResult(32'h820, 4'd8, 1'b1);
      expectResult(32'h810, 4'd0, 1'b0);
      expectResult(32'h821, 4'd9, 1'b1);
      expectResult(32'h811, 4'd1, 1'b0);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 32'h810 + 32'(i), 4'(i), 1'b1, 32'h820 + 32'(i), 4'(8 + i));
      bus.alu_ready      = 1'b0;
      bus.mem_data_ready = 1'b0;
`ifdef CDB_STATS_EN
      checkOutput("t6_conflict_cnt", 64'(bus.cdb_conflict_cnt), 64'd4);
`endif
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("t6_rst_ready", 64'(bus.cdb_ready), 64'd0);
      checkOutput("t6_rst_val",   64'(bus.cdb_val),   64'd0);
      checkOutput("t6_rst_id",    64'(bus.cdb_id),    64'd0);
`ifdef CDB_STATS_EN
      checkOutput("t6_rst_conflict", 64'(bus.cdb_conflict_cnt), 64'd0);
`endif
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      idle(3);
      checkOutput("t6_post_rst_ready", 64'(bus.cdb_ready), 64'd0);
      waitDrain("t6_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
